// File: rtl/aes_pkg.sv
// Shared AES definitions: field arithmetic, S-boxes, round constants, key schedule
// helpers and the decryptor FSM state type.
package aes_pkg;

  localparam int AES_NR = 10;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef enum logic [2:0] {IDLE, KEXP, ARK0, DROUND, DLAST} aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] key_expand_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward step; rc is the constant that produced the current key.
  function automatic logic [127:0] key_expand_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last is set, InvMixColumns. Byte 0 of the state is bits [127:120].
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [7:0] ak [16];
  logic [7:0] mx [16];

  genvar gi;

  // Byte at (row, col) comes from (row, col - row) of the input state.
  for (gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int SRC = ROW + 4 * (((gi / 4) + 4 - ROW) % 4);
    assign ak[gi] = inv_sbox(state_in[127-8*SRC -: 8]) ^ round_key[127-8*gi -: 8];
    assign state_out[127-8*gi -: 8] = last ? ak[gi] : mx[gi];
  end

  for (gi = 0; gi < 4; gi++) begin : g_col
    assign mx[4*gi+0] = gf_mul(8'h0e, ak[4*gi]) ^ gf_mul(8'h0b, ak[4*gi+1]) ^
                        gf_mul(8'h0d, ak[4*gi+2]) ^ gf_mul(8'h09, ak[4*gi+3]);
    assign mx[4*gi+1] = gf_mul(8'h09, ak[4*gi]) ^ gf_mul(8'h0e, ak[4*gi+1]) ^
                        gf_mul(8'h0b, ak[4*gi+2]) ^ gf_mul(8'h0d, ak[4*gi+3]);
    assign mx[4*gi+2] = gf_mul(8'h0d, ak[4*gi]) ^ gf_mul(8'h09, ak[4*gi+1]) ^
                        gf_mul(8'h0e, ak[4*gi+2]) ^ gf_mul(8'h0b, ak[4*gi+3]);
    assign mx[4*gi+3] = gf_mul(8'h0b, ak[4*gi]) ^ gf_mul(8'h0d, ak[4*gi+1]) ^
                        gf_mul(8'h09, ak[4*gi+2]) ^ gf_mul(8'h0e, ak[4*gi+3]);
  end

endmodule

// File: rtl/aes_decryptor_iter.sv
// Iterative AES-128 decryptor, one round per clock: forward key expansion to round key 10,
// then inverse rounds with on-the-fly inverse key schedule. AES_DEC_KEY_CACHE_EN enables a key cache.
module aes_decryptor_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128,
  parameter int NR       = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  if (KEY_BITS != 128 || NR != AES_NR) begin : g_param_check
    $error("aes_decryptor_iter supports AES-128 only (KEY_BITS=128, NR=10)");
  end

  aes_state_e   state_reg;
  logic [3:0]   rc_reg;
  logic [127:0] rk_reg;
  logic [127:0] ct_reg;
  logic [127:0] st_reg;
  logic [127:0] data_out_reg;
  logic         out_valid_reg;

  logic [7:0]   rcon_sel;
  logic [127:0] rk_fwd;
  logic [127:0] rk_inv;
  logic [127:0] round_out;
  logic         last_round;

  assign in_ready   = (state_reg == IDLE) && !out_valid_reg;
  assign out_valid  = out_valid_reg;
  assign data_out   = data_out_reg;
  assign last_round = (state_reg == DLAST);

  // ARK0 steps round key 10 back to 9, which is always rcon[9] whatever rc holds.
  assign rcon_sel = (state_reg == ARK0) ? RCON[AES_NR-1] : RCON[rc_reg];
  assign rk_fwd   = key_expand_fwd(rk_reg, rcon_sel);
  assign rk_inv   = key_expand_inv(rk_reg, rcon_sel);

  aes_inv_round u_round (
    .state_in  (st_reg),
    .round_key (rk_reg),
    .last      (last_round),
    .state_out (round_out)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key_reg;
  logic [127:0] cache_rk_reg;
  logic         cache_vld_reg;
  logic         cache_hit;

  assign cache_hit = cache_vld_reg && (key_in == cache_key_reg);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rc_reg        <= 4'd0;
      rk_reg        <= '0;
      ct_reg        <= '0;
      st_reg        <= '0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key_reg <= '0;
      cache_rk_reg  <= '0;
      cache_vld_reg <= 1'b0;
`endif
    end else begin
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            ct_reg <= data_in;
            rc_reg <= 4'd0;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_hit) begin
              rk_reg    <= cache_rk_reg;
              state_reg <= ARK0;
            end else begin
              // The key is captured now, so the cache only needs round key 10
              // at the end of KEXP; no other accept can intervene before then.
              rk_reg        <= key_in;
              cache_key_reg <= key_in;
              cache_vld_reg <= 1'b0;
              state_reg     <= KEXP;
            end
`else
            rk_reg    <= key_in;
            state_reg <= KEXP;
`endif
          end
        end

        KEXP: begin
          rk_reg <= rk_fwd;
          if (rc_reg == 4'(AES_NR - 1)) begin
            state_reg <= ARK0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_rk_reg  <= rk_fwd;
            cache_vld_reg <= 1'b1;
`endif
          end else begin
            rc_reg <= rc_reg + 4'd1;
          end
        end

        ARK0: begin
          st_reg    <= ct_reg ^ rk_reg;
          rk_reg    <= rk_inv;
          rc_reg    <= 4'(AES_NR - 2);
          state_reg <= DROUND;
        end

        DROUND: begin
          st_reg <= round_out;
          rk_reg <= rk_inv;
          if (rc_reg == 4'd0) state_reg <= DLAST;
          else                rc_reg    <= rc_reg - 4'd1;
        end

        DLAST: begin
          data_out_reg  <= round_out;
          out_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
